// File: rtl/pz_loader.sv
// pz_loader: loads a framed pole/zero set into shadow registers and commits it atomically.
// Define PZ_LOADER_ZERO_FILL_EN to zero unused committed entries on commit.
module pz_loader #(
  parameter int REG_FILE_SIZE = 2,
  parameter int DATA_SIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [DATA_SIZE-1:0]               in_data,
  output logic                               in_ready,
  output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
  output logic [31:0]                        no_z,
  output logic [31:0]                        no_p,
  output logic                               load_done,
  output logic                               load_err,
  output logic                               busy
);
  localparam logic [1:0] S_HDR_Z = 2'd0;
  localparam logic [1:0] S_HDR_P = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;
  localparam int FW = DATA_SIZE * REG_FILE_SIZE;
  logic [1:0] r_state;
  logic [31:0] r_sz, r_sp, r_idx;
  logic [FW-1:0] r_sh;
  logic w_acc;
  logic [31:0] w_cnt, w_hsum, w_tot;
  logic [FW-1:0] w_commit;
  assign in_ready = r_state != S_COMMIT;
  assign busy = r_state != S_HDR_Z;
  assign w_acc = in_valid && in_ready;
  assign w_cnt = 32'(in_data);
  assign w_hsum = r_sz + w_cnt;
  assign w_tot = r_sz + r_sp;
  always_comb begin
    w_commit = r_sh;
`ifdef PZ_LOADER_ZERO_FILL_EN
    for (int i = 0; i < REG_FILE_SIZE; i++)
      if (32'(i) >= w_tot) w_commit[DATA_SIZE*i +: DATA_SIZE] = '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR_Z;
      r_sz <= '0;
      r_sp <= '0;
      r_idx <= '0;
      r_sh <= '0;
      flat_pz <= '0;
      no_z <= '0;
      no_p <= '0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err <= 1'b0;
      case (r_state)
        S_HDR_Z: if (w_acc) begin
          r_sz <= w_cnt;
          r_state <= S_HDR_P;
        end
        S_HDR_P: if (w_acc) begin
          r_sp <= w_cnt;
          r_idx <= '0;
          if (w_hsum > 32'(REG_FILE_SIZE)) begin
            load_err <= 1'b1;
            r_state <= S_HDR_Z;
          end else r_state <= (w_hsum == '0) ? S_COMMIT : S_DATA;
        end
        S_DATA: if (w_acc) begin
          for (int i = 0; i < REG_FILE_SIZE; i++)
            if (r_idx == 32'(i)) r_sh[DATA_SIZE*i +: DATA_SIZE] <= in_data;
          r_idx <= r_idx + 32'd1;
          if (r_idx == w_tot - 32'd1) r_state <= S_COMMIT;
        end
        default: begin
          flat_pz <= w_commit;
          no_z <= r_sz;
          no_p <= r_sp;
          load_done <= 1'b1;
          r_state <= S_HDR_Z;
        end
      endcase
    end
  end
endmodule

// File: doc/pz_loader.md
PZ_LOADER -- requirements
Module: pz_loader

Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 2, meaning the number of pole/zero entries in the flat register file.
REQ-002 SHALL have parameter DATA_SIZE, default 16, meaning the width in bits of one entry and of one input word.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-006 SHALL have port in_data, input, DATA_SIZE bits: the input word (header or entry).
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-008 SHALL have port flat_pz, output, DATA_SIZE*REG_FILE_SIZE bits: committed entries; entry i occupies bits [DATA_SIZE*i +: DATA_SIZE].
REQ-009 SHALL have port no_z, output, 32 bits: committed zero count.
REQ-010 SHALL have port no_p, output, 32 bits: committed pole count.
REQ-011 SHALL have port load_done, output, 1 bit: one-cycle pulse when a new set is committed.
REQ-012 SHALL have port load_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than S_HDR_Z.

Function
REQ-014 A word SHALL be accepted only on a cycle where in_valid and in_ready are both high.
REQ-015 Frame format SHALL be: word 0 = zero count, word 1 = pole count, then no_z zero entries, then no_p pole entries.
REQ-016 Both count words SHALL be zero-extended from DATA_SIZE to 32 bits.
REQ-017 The FSM SHALL have the states S_HDR_Z, S_HDR_P, S_DATA and S_COMMIT.
REQ-018 in_ready SHALL be high in S_HDR_Z, S_HDR_P and S_DATA, and low in S_COMMIT.
REQ-019 S_HDR_Z SHALL, on acceptance, latch the zero count into a shadow register and go to S_HDR_P.
REQ-020 S_HDR_P SHALL, on acceptance, latch the pole count into a shadow register.
REQ-021 From S_HDR_P, if shadow_z + count > REG_FILE_SIZE (32-bit compare), the FSM SHALL pulse load_err, leave the committed outputs untouched and go to S_HDR_Z.
REQ-022 From S_HDR_P, if shadow_z + count = 0, the FSM SHALL go to S_COMMIT.
REQ-023 From S_HDR_P, in all other cases, the FSM SHALL clear the write index and go to S_DATA.
REQ-024 S_DATA SHALL write each accepted word into shadow entry[index] and increment the index.
REQ-025 S_DATA SHALL go to S_COMMIT after the word with index = shadow_z + shadow_p - 1 is accepted.
REQ-026 S_COMMIT SHALL last exactly one cycle, then return to S_HDR_Z.
REQ-027 In S_COMMIT, the shadow entries and counts SHALL be copied to flat_pz, no_z and no_p in a single atomic update, with load_done high for that one cycle.
REQ-028 Latency SHALL be: the committed outputs and load_done change on the clock edge one cycle after the edge that accepts the last word.
REQ-029 Committed outputs SHALL never hold a partially loaded set; shadow entries at index >= shadow_z + shadow_p SHALL keep their previous contents unless REQ-036 applies.
REQ-030 If in_valid drops mid-frame, the FSM SHALL hold its state and index until the next word arrives; no timeout.
REQ-031 Back-to-back frames SHALL be supported: the first header of the next frame may be presented on the cycle after S_COMMIT.

Reset
REQ-032 When rst is high at a clock edge, all outputs SHALL reset: flat_pz=0, no_z=0, no_p=0, load_done=0, load_err=0, busy=0.
REQ-033 When rst is high at a clock edge, the FSM SHALL go to S_HDR_Z, and the shadow registers and the index SHALL be cleared.
REQ-034 in_ready SHALL be high on the first cycle after reset is released.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; the committed outputs become zero, not the last committed set.

Configuration
REQ-036 With PZ_LOADER_ZERO_FILL_EN defined, S_COMMIT SHALL also force every committed entry at index >= no_z + no_p to zero.
REQ-037 Without PZ_LOADER_ZERO_FILL_EN, unused committed entries SHALL retain the values of the previous shadow contents.

Verification (REG_FILE_SIZE=2, DATA_SIZE=16)
REQ-038 Basic load: stream 1, 1, 0x0010, 0x0004 with in_valid held high -> one cycle after the last word, flat_pz=0x0004_0010, no_z=1, no_p=1, and load_done high for exactly one cycle.
REQ-039 Overflow: stream 2, 1 -> load_err pulses after the second word, the outputs keep the previous set, and a following valid frame loads correctly.
REQ-040 Empty frame: stream 0, 0 -> load_done pulses after the second word with no_z=0 and no_p=0; flat_pz is zero with ZERO_FILL and unchanged without it.
REQ-041 Stall: stream 0, 2, 0x1111, [in_valid low for 5 cycles], 0x2222 -> busy stays high during the gap, and the result is flat_pz=0x2222_1111, no_p=2.
REQ-042 Reset mid-frame: stream 1, 1, 0x00AA, then assert rst -> all outputs are 0, and the next frame 1, 0, 0x0005 gives flat_pz[15:0]=0x0005 and no_z=1.
